median_result_writer: RTL and testbench

- Downstream of the median filtering stage.
- Consumes the stream of 1-bit median results, one per window position, with their window-origin coordinates.
- Packs results LSB-first into 8-bit words in raster order and writes them to the output frame buffer through a small FIFO with backpressure.
- Signals frame completion and flags sequence or overflow faults.

---
 rtl/median_result_writer.sv | 179 +++++++++++++++++
 tb/tb_median_result_writer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/median_result_writer.sv
// Packs 1-bit median results into raster-ordered bytes and writes them through a small FIFO.
// Optional MEDIAN_POPCOUNT_EN adds a saturating count of accepted ones (onesCount).
module median_result_writer #(
   parameter int unsigned OUT_WIDTH      = 238,
   parameter int unsigned OUT_HEIGHT     = 178,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned MEM_ADDR_WIDTH = 13
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      resultValid,
   input  logic                      resultBit,
   input  logic [7:0]                xResultAddr,
   input  logic [7:0]                yResultAddr,
   input  logic                      memReady,
   output logic                      memWe,
   output logic [MEM_ADDR_WIDTH-1:0] memAddr,
   output logic [7:0]                memData,
   output logic                      writerBusy,
   output logic                      writerDone,
`ifdef MEDIAN_POPCOUNT_EN
   output logic [15:0]               onesCount,
`endif
   output logic                      seqError,
   output logic                      overflow
);

   localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = MEM_ADDR_WIDTH + 8;

   typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_FLUSH, S_DONE} state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic [7:0]                r_exp_x;
   logic [7:0]                r_exp_y;
   logic [2:0]                r_bit_idx;
   logic [7:0]                r_shift;
   logic [MEM_ADDR_WIDTH-1:0] r_waddr;
   logic                      r_seq_err;
   logic                      r_overflow;
   logic                      r_busy;
   logic                      r_done;
   logic [ENTRY_W-1:0]        r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]          r_wr_ptr;
   logic [PTR_W-1:0]          r_rd_ptr;
   logic [CNT_W-1:0]          r_count;

   logic                      w_start;
   logic                      w_accept;
   logic                      w_last_x;
   logic                      w_last_y;
   logic                      w_last_pix;
   logic [7:0]                w_word;
   logic                      w_push;
   logic                      w_push_ok;
   logic                      w_empty;
   logic                      w_full;
   logic                      w_pop;
   logic [ENTRY_W-1:0]        w_head;

   assign w_start    = (r_state == S_IDLE) && start;
   assign w_accept   = (r_state == S_ACCEPT) && resultValid;
   assign w_last_x   = (r_exp_x == 8'(OUT_WIDTH - 1));
   assign w_last_y   = (r_exp_y == 8'(OUT_HEIGHT - 1));
   assign w_last_pix = w_last_x && w_last_y;
   // Bits above r_bit_idx are always zero because the shifter is cleared on every push
   assign w_word     = r_shift | (8'(resultBit) << r_bit_idx);
   assign w_push     = w_accept && ((r_bit_idx == 3'd7) || w_last_pix);
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_pop      = !w_empty && memReady;
   // A same-cycle pop frees the slot, so a push into a full FIFO still lands
   assign w_push_ok  = w_push && (!w_full || w_pop);
   assign w_head     = r_fifo[r_rd_ptr];

   assign memWe      = w_pop;
   assign memAddr    = w_empty ? '0 : w_head[ENTRY_W-1:8];
   assign memData    = w_empty ? '0 : w_head[7:0];
   assign writerBusy = r_busy;
   assign writerDone = r_done;
   assign seqError   = r_seq_err;
   assign overflow   = r_overflow;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next_state = S_ACCEPT;
         S_ACCEPT: if (w_accept && w_last_pix) w_next_state = S_FLUSH;
         S_FLUSH:  if (w_empty) w_next_state = S_DONE;
         S_DONE:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Status flags track the next state so they line up with the state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_next_state == S_ACCEPT) || (w_next_state == S_FLUSH);
         r_done <= (w_next_state == S_DONE);
      end
   end

   // Packing, raster tracking and sticky fault flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_exp_x    <= '0;
         r_exp_y    <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_waddr    <= '0;
         r_seq_err  <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_start) begin
         r_exp_x    <= '0;
         r_exp_y    <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_waddr    <= '0;
         r_seq_err  <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_accept) begin
         r_bit_idx <= r_bit_idx + 3'd1;
         if ((xResultAddr != r_exp_x) || (yResultAddr != r_exp_y)) r_seq_err <= 1'b1;
         if (w_last_x) begin
            r_exp_x <= '0;
            r_exp_y <= w_last_y ? 8'd0 : r_exp_y + 8'd1;
         end else begin
            r_exp_x <= r_exp_x + 8'd1;
         end
         if (w_push) begin
            r_shift <= '0;
            r_waddr <= r_waddr + MEM_ADDR_WIDTH'(1);
            if (!w_push_ok) r_overflow <= 1'b1;
         end else begin
            r_shift <= w_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
      end
   end

   // Storage needs no reset; the empty flag masks stale entries
   always_ff @(posedge clk) begin
      if (w_push_ok) r_fifo[r_wr_ptr] <= {r_waddr, w_word};
   end

`ifdef MEDIAN_POPCOUNT_EN
   logic [15:0] r_ones;

   always_ff @(posedge clk) begin
      if (reset || w_start)                                  r_ones <= '0;
      else if (w_accept && resultBit && (r_ones != 16'hFFFF)) r_ones <= r_ones + 16'd1;
   end

   assign onesCount = r_ones;
`endif

endmodule

// File: tb/tb_median_result_writer.sv
// Self-checking bench for median_result_writer on a reduced frame (41x26 results, 134 words).
module tb_median_result_writer;

   localparam int unsigned OW     = 41;
   localparam int unsigned OH     = 26;
   localparam int unsigned FD     = 4;
   localparam int unsigned AW     = 8;
   localparam int          NPIX   = OW * OH;
   localparam int          NWORDS = (NPIX + 7) / 8;

   logic          clk = 1'b0;
   logic          reset, start, resultValid, resultBit, memReady;
   logic [7:0]    xResultAddr, yResultAddr;
   logic          memWe;
   logic [AW-1:0] memAddr;
   logic [7:0]    memData;
   logic          writerBusy, writerDone, seqError, overflow;
`ifdef MEDIAN_POPCOUNT_EN
   logic [15:0]   onesCount;
`endif

   always #5 clk = ~clk;

   median_result_writer #(
      .OUT_WIDTH(OW), .OUT_HEIGHT(OH), .FIFO_DEPTH(FD), .MEM_ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .resultValid(resultValid),
      .resultBit(resultBit), .xResultAddr(xResultAddr), .yResultAddr(yResultAddr),
      .memReady(memReady), .memWe(memWe), .memAddr(memAddr), .memData(memData),
      .writerBusy(writerBusy), .writerDone(writerDone),
`ifdef MEDIAN_POPCOUNT_EN
      .onesCount(onesCount),
`endif
      .seqError(seqError), .overflow(overflow)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   typedef struct {
      int         mode;       // 0 alternating 1,0  1 all ones  2 random  3 1000 ones then zeros
      int         stall_n;    // memReady held low for the first stall_n results
      int         err_at;     // result index sent with a wrong column, -1 for none
      int         drop_addr;  // word address expected to be lost to overflow, -1 for none
      int         exp_writes;
      logic       exp_seq;
      logic       exp_ovf;
      bit         chk_last;
      logic [7:0] exp_last;
   } vec_t;

   int  n_checks = 0;
   int  n_pass   = 0;
   wr_t exp_q[$];
   int  wr_count, done_count;
   wr_t last_wr;
   int  m_idx, m_shift, m_addr, m_drop;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard: every write must match the oldest expected word
   always @(negedge clk) begin
      if (memWe) begin
         wr_count++;
         last_wr = {memAddr, memData};
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none", memAddr, memData);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(memAddr), 32'(e.addr));
            check("wr_data", 32'(memData), 32'(e.data));
         end
      end
      if (writerDone) done_count++;
   end

   function automatic logic pix_bit(input int mode, input int p);
      case (mode)
         0:       return (p % 2) == 0;
         1:       return 1'b1;
         3:       return p < 1000;
         default: return 1'($urandom);
      endcase
   endfunction

   task automatic send(input logic b, input logic [7:0] x, input logic [7:0] y, input bit last);
      resultValid = 1'b1; resultBit = b; xResultAddr = x; yResultAddr = y;
      m_shift = m_shift | (int'(b) << m_idx);
      m_idx++;
      if (m_idx == 8 || last) begin
         if (m_addr != m_drop) exp_q.push_back('{addr: AW'(m_addr), data: 8'(m_shift)});
         m_addr++; m_shift = 0; m_idx = 0;
      end
      @(posedge clk); #1;
      resultValid = 1'b0;
   endtask

   task automatic do_start(input int drop);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_idx = 0; m_shift = 0; m_addr = 0; m_drop = drop;
      wr_count = 0; done_count = 0;
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      do_start(v.drop_addr);
      @(negedge clk);
      check({tag, "_busy_after_start"}, 32'(writerBusy), 32'd1);
      check({tag, "_seq_clear_on_start"}, 32'(seqError), 32'd0);
      check({tag, "_ovf_clear_on_start"}, 32'(overflow), 32'd0);
      for (int p = 0; p < NPIX; p++) begin
         logic [7:0] x;
         memReady = (p < v.stall_n) ? 1'b0 : 1'b1;
         x = (p == v.err_at) ? 8'd5 : 8'(p % OW);
         send(pix_bit(v.mode, p), x, 8'(p / OW), p == NPIX - 1);
         if (v.stall_n > 0 && p == v.stall_n - 1) begin
            @(negedge clk);
            check({tag, "_ovf_after_stall"}, 32'(overflow), 32'd1);
            check({tag, "_fifo_depth_held"}, 32'(exp_q.size()), 32'(FD));
         end
      end
      memReady = 1'b1;
      for (int i = 0; i < 200 && done_count == 0; i++) @(negedge clk);
      @(negedge clk);
      check({tag, "_done_pulses"}, 32'(done_count), 32'd1);
      check({tag, "_done_low"}, 32'(writerDone), 32'd0);
      check({tag, "_busy_low"}, 32'(writerBusy), 32'd0);
      check({tag, "_writes"}, 32'(wr_count), 32'(v.exp_writes));
      check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_seq_error"}, 32'(seqError), 32'(v.exp_seq));
      check({tag, "_overflow"}, 32'(overflow), 32'(v.exp_ovf));
      if (v.chk_last) begin
         check({tag, "_last_addr"}, 32'(last_wr.addr), 32'(NWORDS - 1));
         check({tag, "_last_data"}, 32'(last_wr.data), 32'(v.exp_last));
      end
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{mode: 0, stall_n: 0,  err_at: -1, drop_addr: -1, exp_writes: NWORDS,
                  exp_seq: 1'b0, exp_ovf: 1'b0, chk_last: 1'b1, exp_last: 8'h01};
      vecs[1] = '{mode: 1, stall_n: 0,  err_at: -1, drop_addr: -1, exp_writes: NWORDS,
                  exp_seq: 1'b0, exp_ovf: 1'b0, chk_last: 1'b1, exp_last: 8'h03};
      vecs[2] = '{mode: 1, stall_n: 40, err_at: -1, drop_addr: 4,  exp_writes: NWORDS - 1,
                  exp_seq: 1'b0, exp_ovf: 1'b1, chk_last: 1'b1, exp_last: 8'h03};
      vecs[3] = '{mode: 1, stall_n: 0,  err_at: 7,  drop_addr: -1, exp_writes: NWORDS,
                  exp_seq: 1'b1, exp_ovf: 1'b0, chk_last: 1'b1, exp_last: 8'h03};
      vecs[4] = '{mode: 2, stall_n: 0,  err_at: -1, drop_addr: -1, exp_writes: NWORDS,
                  exp_seq: 1'b0, exp_ovf: 1'b0, chk_last: 1'b0, exp_last: 8'h00};

      reset = 1'b1; start = 1'b0; resultValid = 1'b0; resultBit = 1'b0;
      xResultAddr = '0; yResultAddr = '0; memReady = 1'b1;
      m_idx = 0; m_shift = 0; m_addr = 0; m_drop = -1; wr_count = 0; done_count = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_memWe", 32'(memWe), 32'd0);
      check("rst_memAddr", 32'(memAddr), 32'd0);
      check("rst_memData", 32'(memData), 32'd0);
      check("rst_busy", 32'(writerBusy), 32'd0);
      check("rst_done", 32'(writerDone), 32'd0);
      check("rst_seq", 32'(seqError), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      // Results while idle must be ignored
      @(posedge clk); #1;
      resultValid = 1'b1; resultBit = 1'b1;
      repeat (10) @(posedge clk);
      #1 resultValid = 1'b0;
      @(negedge clk);
      check("idle_ignores_results", 32'(writerBusy), 32'd0);
      check("idle_no_write", 32'(wr_count), 32'd0);

      for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

      // Reset mid-frame with two words buffered
      do_start(-1);
      memReady = 1'b0;
      for (int p = 0; p < 16; p++) send(1'b1, 8'(p % OW), 8'(p / OW), 1'b0);
      @(negedge clk);
      check("midrst_buffered", 32'(exp_q.size()), 32'd2);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0; memReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst_no_write", 32'(memWe), 32'd0);
      end
      check("midrst_busy", 32'(writerBusy), 32'd0);
      check("midrst_addr", 32'(memAddr), 32'd0);
      check("midrst_data", 32'(memData), 32'd0);
      run_frame(vecs[1], "after_rst");

      // Start while busy must not restart the frame
      do_start(-1);
      for (int p = 0; p < 4; p++) send(1'b1, 8'(p % OW), 8'(p / OW), 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int p = 4; p < NPIX; p++) send(1'b1, 8'(p % OW), 8'(p / OW), p == NPIX - 1);
      for (int i = 0; i < 200 && done_count == 0; i++) @(negedge clk);
      @(negedge clk);
      check("busy_start_done", 32'(done_count), 32'd1);
      check("busy_start_seq", 32'(seqError), 32'd0);
      check("busy_start_writes", 32'(wr_count), 32'(NWORDS));

`ifdef MEDIAN_POPCOUNT_EN
      run_frame('{mode: 3, stall_n: 0, err_at: -1, drop_addr: -1, exp_writes: NWORDS,
                  exp_seq: 1'b0, exp_ovf: 1'b0, chk_last: 1'b1, exp_last: 8'h00}, "pop");
      check("pop_count", 32'(onesCount), 32'd1000);
      do_start(-1);
      @(negedge clk);
      check("pop_clear", 32'(onesCount), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
